// File: rtl/nanorv32_ahb_arbiter.sv
// Two-master AHB-lite arbiter: nanorv32 instruction (I) and data (D) masters
// share one slave port. An uncontested transfer passes through combinationally.
// A losing transfer is buffered, and its data phase is stretched until the
// buffered transfer is replayed on the slave port.
module nanorv32_ahb_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    // I-side master
    input  logic [31:0] haddri,
    input  logic        htransi,
    input  logic [2:0]  hsizei,
    input  logic [3:0]  hproti,
    output logic [31:0] hrdatai,
    output logic        hreadyi,
    output logic        hrespi,
    // D-side master
    input  logic [31:0] haddrd,
    input  logic        htransd,
    input  logic [2:0]  hsized,
    input  logic [3:0]  hprotd,
    input  logic        hwrited,
    input  logic [31:0] hwdatad,
    output logic [31:0] hrdatad,
    output logic        hreadyd,
    output logic        hrespd,
    // Slave port
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic [2:0]  hsize,
    output logic [3:0]  hprot,
    output logic        hwrite,
    output logic [31:0] hwdata,
    output logic        hmaster,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } own_e;

    own_e        dp_own_q, dp_own_d;
    logic [3:0]  starve_q, starve_d;

    // Pending buffers
    logic        pend_i_q, pend_i_d;
    logic [31:0] pa_i_q, pa_i_d;
    logic [2:0]  ps_i_q, ps_i_d;
    logic [3:0]  pp_i_q, pp_i_d;
    logic        pend_d_q, pend_d_d;
    logic [31:0] pa_d_q, pa_d_d;
    logic [2:0]  ps_d_q, ps_d_d;
    logic [3:0]  pp_d_q, pp_d_d;
    logic        pw_d_q, pw_d_d;

    // Last granted address-phase fields, held while the bus is idle
    logic [31:0] haddr_q, haddr_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [3:0]  hprot_q, hprot_d;
    logic        hwrite_q, hwrite_d;
    logic        hmaster_q, hmaster_d;

    logic        live_i, live_d, req_i, req_d, gnt_i, gnt_d, gnt_any;
    logic [31:0] src_addr;
    logic [2:0]  src_size;
    logic [3:0]  src_prot;
    logic        src_write;

    // Master-side ready, response and read data
    always_comb begin
        hreadyi = 1'b1;
        if (dp_own_q == OWN_I)  hreadyi = hready & ~pend_i_q;
        else if (pend_i_q)      hreadyi = 1'b0;
        hreadyd = 1'b1;
        if (dp_own_q == OWN_D)  hreadyd = hready & ~pend_d_q;
        else if (pend_d_q)      hreadyd = 1'b0;
        hrespi  = (dp_own_q == OWN_I) ? hresp : 1'b0;
        hrespd  = (dp_own_q == OWN_D) ? hresp : 1'b0;
        hrdatai = hrdata;
        hrdatad = hrdata;
        hwdata  = (dp_own_q == OWN_D) ? hwdatad : 32'h0;
    end

    // Requests and fixed-priority arbitration with I starvation override
    always_comb begin
        live_i  = htransi & hreadyi & ~pend_i_q;
        live_d  = htransd & hreadyd & ~pend_d_q;
        req_i   = pend_i_q | live_i;
        req_d   = pend_d_q | live_d;
        gnt_d   = hready & req_d & ~(req_i & (starve_q == STARVE_LIM));
        gnt_i   = hready & req_i & ~gnt_d;
        gnt_any = gnt_i | gnt_d;
    end

    // Grant source select: buffered fields take precedence over live inputs
    always_comb begin
        src_addr  = pend_i_q ? pa_i_q : haddri;
        src_size  = pend_i_q ? ps_i_q : hsizei;
        src_prot  = pend_i_q ? pp_i_q : hproti;
        src_write = 1'b0;
        if (gnt_d) begin
            src_addr  = pend_d_q ? pa_d_q : haddrd;
            src_size  = pend_d_q ? ps_d_q : hsized;
            src_prot  = pend_d_q ? pp_d_q : hprotd;
            src_write = pend_d_q ? pw_d_q : hwrited;
        end
    end

    // Slave address-phase outputs
    always_comb begin
        htrans  = gnt_any ? 2'b10 : 2'b00;
        haddr   = gnt_any ? src_addr  : haddr_q;
        hsize   = gnt_any ? src_size  : hsize_q;
        hprot   = gnt_any ? src_prot  : hprot_q;
        hwrite  = gnt_any ? src_write : hwrite_q;
        hmaster = gnt_any ? gnt_d     : hmaster_q;
    end

    // Next-state: buffers, data-phase owner, starvation counter, held fields
    always_comb begin
        pend_i_d  = pend_i_q;
        pa_i_d    = pa_i_q;
        ps_i_d    = ps_i_q;
        pp_i_d    = pp_i_q;
        pend_d_d  = pend_d_q;
        pa_d_d    = pa_d_q;
        ps_d_d    = ps_d_q;
        pp_d_d    = pp_d_q;
        pw_d_d    = pw_d_q;
        dp_own_d  = dp_own_q;
        starve_d  = starve_q;
        haddr_d   = haddr_q;
        hsize_d   = hsize_q;
        hprot_d   = hprot_q;
        hwrite_d  = hwrite_q;
        hmaster_d = hmaster_q;

        if (gnt_i) begin
            pend_i_d = 1'b0;
        end else if (live_i) begin
            pend_i_d = 1'b1;
            pa_i_d   = haddri;
            ps_i_d   = hsizei;
            pp_i_d   = hproti;
        end

        if (gnt_d) begin
            pend_d_d = 1'b0;
        end else if (live_d) begin
            pend_d_d = 1'b1;
            pa_d_d   = haddrd;
            ps_d_d   = hsized;
            pp_d_d   = hprotd;
            pw_d_d   = hwrited;
        end

        if (hready) begin
            if (gnt_d)      dp_own_d = OWN_D;
            else if (gnt_i) dp_own_d = OWN_I;
            else            dp_own_d = OWN_NONE;

            if (gnt_i)
                starve_d = '0;
            else if (req_i && (starve_q != STARVE_LIM))
                starve_d = starve_q + 4'd1;
        end

        if (gnt_any) begin
            haddr_d   = src_addr;
            hsize_d   = src_size;
            hprot_d   = src_prot;
            hwrite_d  = src_write;
            hmaster_d = gnt_d;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_i_q  <= 1'b0;
            pa_i_q    <= '0;
            ps_i_q    <= '0;
            pp_i_q    <= '0;
            pend_d_q  <= 1'b0;
            pa_d_q    <= '0;
            ps_d_q    <= '0;
            pp_d_q    <= '0;
            pw_d_q    <= 1'b0;
            dp_own_q  <= OWN_NONE;
            starve_q  <= '0;
            haddr_q   <= '0;
            hsize_q   <= '0;
            hprot_q   <= '0;
            hwrite_q  <= 1'b0;
            hmaster_q <= 1'b0;
        end else begin
            pend_i_q  <= pend_i_d;
            pa_i_q    <= pa_i_d;
            ps_i_q    <= ps_i_d;
            pp_i_q    <= pp_i_d;
            pend_d_q  <= pend_d_d;
            pa_d_q    <= pa_d_d;
            ps_d_q    <= ps_d_d;
            pp_d_q    <= pp_d_d;
            pw_d_q    <= pw_d_d;
            dp_own_q  <= dp_own_d;
            starve_q  <= starve_d;
            haddr_q   <= haddr_d;
            hsize_q   <= hsize_d;
            hprot_q   <= hprot_d;
            hwrite_q  <= hwrite_d;
            hmaster_q <= hmaster_d;
        end
    end

endmodule

// File: tb/tb_nanorv32_ahb_arbiter.sv
// Directed testbench for nanorv32_ahb_arbiter with a simple AHB-lite slave
// model: read data is the address XOR a fixed pattern, except for the last
// written word, which reads back what was written.
module tb_nanorv32_ahb_arbiter;

    localparam logic [31:0] PAT = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] haddri;
    logic        htransi;
    logic [2:0]  hsizei;
    logic [3:0]  hproti;
    logic [31:0] hrdatai;
    logic        hreadyi;
    logic        hrespi;
    logic [31:0] haddrd;
    logic        htransd;
    logic [2:0]  hsized;
    logic [3:0]  hprotd;
    logic        hwrited;
    logic [31:0] hwdatad;
    logic [31:0] hrdatad;
    logic        hreadyd;
    logic        hrespd;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hmaster;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    nanorv32_ahb_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .haddri(haddri), .htransi(htransi), .hsizei(hsizei), .hproti(hproti),
        .hrdatai(hrdatai), .hreadyi(hreadyi), .hrespi(hrespi),
        .haddrd(haddrd), .htransd(htransd), .hsized(hsized), .hprotd(hprotd),
        .hwrited(hwrited), .hwdatad(hwdatad),
        .hrdatad(hrdatad), .hreadyd(hreadyd), .hrespd(hrespd),
        .haddr(haddr), .htrans(htrans), .hsize(hsize), .hprot(hprot),
        .hwrite(hwrite), .hwdata(hwdata), .hmaster(hmaster),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    // Slave model
    logic        s_dp_v, s_dp_w, w_v;
    logic [31:0] s_dp_a, w_a, w_d, s_rdata;
    assign hrdata = s_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_dp_v <= 1'b0; s_dp_w <= 1'b0; s_dp_a <= '0;
            w_v <= 1'b0; w_a <= '0; w_d <= '0; s_rdata <= '0;
        end else if (hready) begin
            if (s_dp_v && s_dp_w) begin
                w_v <= 1'b1; w_a <= s_dp_a; w_d <= hwdata;
            end
            s_dp_v <= htrans[1];
            s_dp_a <= haddr;
            s_dp_w <= hwrite;
            if (s_dp_v && s_dp_w && s_dp_a == haddr) s_rdata <= hwdata;
            else if (w_v && w_a == haddr)           s_rdata <= w_d;
            else                                    s_rdata <= haddr ^ PAT;
        end
    end

    // Masters must not present a new transfer while their buffered one waits
    always @(negedge clk) begin
        if (rst_n === 1'b1 && hready === 1'b1) begin
            assert (!(htransi && !hreadyi)) else begin
                fails++;
                $display("FAIL proto_i: htransi=%b while hreadyi=%b", htransi, hreadyi);
            end
            assert (!(htransd && !hreadyd)) else begin
                fails++;
                $display("FAIL proto_d: htransd=%b while hreadyd=%b", htransd, hreadyd);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_all();
        htransi = 1'b0; haddri = '0; hsizei = '0; hproti = '0;
        htransd = 1'b0; haddrd = '0; hsized = '0; hprotd = '0;
        hwrited = 1'b0; hwdatad = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hready = 1'b1; hresp = 1'b0;
        idle_all();
        #3;
        checks++; if (htrans !== 2'b00) begin fails++; $display("FAIL reset_htrans: got %b want %b", htrans, 2'b00); end
        checks++; if (haddr !== 32'h0) begin fails++; $display("FAIL reset_haddr: got %h want %h", haddr, 32'h0); end
        checks++; if ({hsize, hprot, hwrite, hmaster} !== 9'h0) begin fails++; $display("FAIL reset_ctrl: got %h want 0", {hsize, hprot, hwrite, hmaster}); end
        checks++; if ({hreadyi, hreadyd} !== 2'b11) begin fails++; $display("FAIL reset_ready: got %b want 11", {hreadyi, hreadyd}); end
        checks++; if ({hrespi, hrespd} !== 2'b00) begin fails++; $display("FAIL reset_resp: got %b want 00", {hrespi, hrespd}); end
        checks++; if (hwdata !== 32'h0) begin fails++; $display("FAIL reset_hwdata: got %h want 0", hwdata); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_i_stream();
        logic [31:0] a;
        step(); idle_all();
        for (int k = 0; k < 3; k++) begin
            step();
            a = 32'(k) * 32'd4;
            htransi = 1'b1; haddri = a; hsizei = 3'd2; hproti = 4'h3;
            #3;
            checks++; if (htrans !== 2'b10) begin fails++; $display("FAIL istream_htrans[%0d]: got %b want 10", k, htrans); end
            checks++; if (haddr !== a) begin fails++; $display("FAIL istream_haddr[%0d]: got %h want %h", k, haddr, a); end
            checks++; if (hmaster !== 1'b0 || hreadyi !== 1'b1) begin fails++; $display("FAIL istream_own[%0d]: got hmaster=%b hreadyi=%b want 0/1", k, hmaster, hreadyi); end
            checks++; if (hsize !== 3'd2 || hprot !== 4'h3 || hwrite !== 1'b0) begin fails++; $display("FAIL istream_ctrl[%0d]: got %h/%h/%b want 2/3/0", k, hsize, hprot, hwrite); end
            if (k > 0) begin
                checks++; if (hrdatai !== ((a - 32'd4) ^ PAT)) begin fails++; $display("FAIL istream_rdata[%0d]: got %h want %h", k, hrdatai, (a - 32'd4) ^ PAT); end
            end
        end
        step(); idle_all(); #3;
        checks++; if (htrans !== 2'b00 || haddr !== 32'h8) begin fails++; $display("FAIL istream_idle_hold: got %b/%h want 00/00000008", htrans, haddr); end
        checks++; if (hrdatai !== (32'h8 ^ PAT)) begin fails++; $display("FAIL istream_rdata_last: got %h want %h", hrdatai, 32'h8 ^ PAT); end
    endtask

    task automatic test_contend_read();
        step(); idle_all();
        step();
        htransd = 1'b1; haddrd = 32'h2000; hsized = 3'd2; hprotd = 4'h1; hwrited = 1'b0;
        htransi = 1'b1; haddri = 32'h100; hsizei = 3'd2; hproti = 4'h2;
        #3;
        checks++; if (hmaster !== 1'b1 || haddr !== 32'h2000 || htrans !== 2'b10) begin fails++; $display("FAIL cread_dgrant: got %b/%h/%b want 1/00002000/10", hmaster, haddr, htrans); end
        checks++; if (hreadyi !== 1'b1 || hreadyd !== 1'b1) begin fails++; $display("FAIL cread_ready0: got %b/%b want 1/1", hreadyi, hreadyd); end
        step(); idle_all(); hresp = 1'b1; #3;
        checks++; if (hmaster !== 1'b0 || haddr !== 32'h100 || htrans !== 2'b10) begin fails++; $display("FAIL cread_ireplay: got %b/%h/%b want 0/00000100/10", hmaster, haddr, htrans); end
        checks++; if (hsize !== 3'd2 || hprot !== 4'h2) begin fails++; $display("FAIL cread_ibuf_ctrl: got %h/%h want 2/2", hsize, hprot); end
        checks++; if (hreadyi !== 1'b0 || hreadyd !== 1'b1) begin fails++; $display("FAIL cread_ready1: got %b/%b want 0/1", hreadyi, hreadyd); end
        checks++; if (hrdatad !== (32'h2000 ^ PAT)) begin fails++; $display("FAIL cread_drdata: got %h want %h", hrdatad, 32'h2000 ^ PAT); end
        checks++; if (hrespd !== 1'b1 || hrespi !== 1'b0) begin fails++; $display("FAIL cread_resp: got d=%b i=%b want 1/0", hrespd, hrespi); end
        step(); hresp = 1'b0; #3;
        checks++; if (hreadyi !== 1'b1 || hrdatai !== (32'h100 ^ PAT)) begin fails++; $display("FAIL cread_irdata: got %b/%h want 1/%h", hreadyi, hrdatai, 32'h100 ^ PAT); end
        checks++; if (htrans !== 2'b00) begin fails++; $display("FAIL cread_idle: got %b want 00", htrans); end
    endtask

    task automatic test_contend_write();
        step(); idle_all();
        step();
        htransd = 1'b1; haddrd = 32'h2004; hsized = 3'd2; hwrited = 1'b1;
        htransi = 1'b1; haddri = 32'h104; hsizei = 3'd2;
        #3;
        checks++; if (hmaster !== 1'b1 || haddr !== 32'h2004 || hwrite !== 1'b1) begin fails++; $display("FAIL cwrite_dgrant: got %b/%h/%b want 1/00002004/1", hmaster, haddr, hwrite); end
        step(); idle_all(); hwdatad = 32'hDEADBEEF; #3;
        checks++; if (hwdata !== 32'hDEADBEEF) begin fails++; $display("FAIL cwrite_hwdata: got %h want deadbeef", hwdata); end
        checks++; if (hmaster !== 1'b0 || haddr !== 32'h104 || hwrite !== 1'b0) begin fails++; $display("FAIL cwrite_ireplay: got %b/%h/%b want 0/00000104/0", hmaster, haddr, hwrite); end
        checks++; if (hreadyi !== 1'b0 || hreadyd !== 1'b1) begin fails++; $display("FAIL cwrite_ready: got %b/%b want 0/1", hreadyi, hreadyd); end
        step(); idle_all();
        htransd = 1'b1; haddrd = 32'h2004; hsized = 3'd2; hwrited = 1'b0;
        #3;
        checks++; if (hwdata !== 32'h0) begin fails++; $display("FAIL cwrite_hwdata_idle: got %h want 0", hwdata); end
        checks++; if (hreadyi !== 1'b1 || hrdatai !== (32'h104 ^ PAT)) begin fails++; $display("FAIL cwrite_irdata: got %b/%h want 1/%h", hreadyi, hrdatai, 32'h104 ^ PAT); end
        checks++; if (hmaster !== 1'b1 || haddr !== 32'h2004 || hwrite !== 1'b0) begin fails++; $display("FAIL cwrite_readback_addr: got %b/%h/%b want 1/00002004/0", hmaster, haddr, hwrite); end
        step(); idle_all(); #3;
        checks++; if (hreadyd !== 1'b1 || hrdatad !== 32'hDEADBEEF) begin fails++; $display("FAIL cwrite_readback: got %b/%h want 1/deadbeef", hreadyd, hrdatad); end
    endtask

    task automatic test_hready_stall();
        step(); idle_all();
        step();
        htransi = 1'b1; haddri = 32'h200; hsizei = 3'd2;
        #3;
        checks++; if (hmaster !== 1'b0 || haddr !== 32'h200) begin fails++; $display("FAIL stall_igrant: got %b/%h want 0/00000200", hmaster, haddr); end
        for (int s = 0; s < 3; s++) begin
            step(); idle_all(); hready = 1'b0;
            if (s == 0) begin htransd = 1'b1; haddrd = 32'h3000; hsized = 3'd2; end
            #3;
            checks++; if (haddr !== 32'h200 || hreadyi !== 1'b0) begin fails++; $display("FAIL stall_hold[%0d]: got %h/%b want 00000200/0", s, haddr, hreadyi); end
            checks++; if (hreadyd !== ((s == 0) ? 1'b1 : 1'b0)) begin fails++; $display("FAIL stall_dready[%0d]: got %b want %b", s, hreadyd, (s == 0)); end
        end
        step(); idle_all(); hready = 1'b1; #3;
        checks++; if (htrans !== 2'b10 || hmaster !== 1'b1 || haddr !== 32'h3000) begin fails++; $display("FAIL stall_dissue: got %b/%b/%h want 10/1/00003000", htrans, hmaster, haddr); end
        checks++; if (hreadyi !== 1'b1 || hrdatai !== (32'h200 ^ PAT) || hreadyd !== 1'b0) begin fails++; $display("FAIL stall_idone: got %b/%h/%b want 1/%h/0", hreadyi, hrdatai, hreadyd, 32'h200 ^ PAT); end
        step(); #3;
        checks++; if (hreadyd !== 1'b1 || hrdatad !== (32'h3000 ^ PAT)) begin fails++; $display("FAIL stall_ddone: got %b/%h want 1/%h", hreadyd, hrdatad, 32'h3000 ^ PAT); end
    endtask

    task automatic test_starvation();
        logic [31:0] da;
        step(); idle_all();
        for (int c = 1; c <= 5; c++) begin
            step();
            da = 32'h4000 + 32'(c - 1) * 32'd4;
            htransd = 1'b1; haddrd = da; hsized = 3'd2;
            htransi = (c == 1); haddri = (c == 1) ? 32'h500 : 32'h0;
            #3;
            if (c < 5) begin
                checks++; if (hmaster !== 1'b1 || haddr !== da) begin fails++; $display("FAIL starve_dwin[%0d]: got %b/%h want 1/%h", c, hmaster, haddr, da); end
            end else begin
                checks++; if (hmaster !== 1'b0 || haddr !== 32'h500) begin fails++; $display("FAIL starve_iforce: got %b/%h want 0/00000500", hmaster, haddr); end
            end
            if (c > 1) begin
                checks++; if (hreadyi !== 1'b0) begin fails++; $display("FAIL starve_istall[%0d]: got %b want 0", c, hreadyi); end
            end
        end
        step(); idle_all(); htransi = 1'b1; haddri = 32'h504; hsizei = 3'd2; #3;
        checks++; if (hreadyi !== 1'b1 || hrdatai !== (32'h500 ^ PAT) || hreadyd !== 1'b0) begin fails++; $display("FAIL starve_idone: got %b/%h/%b want 1/%h/0", hreadyi, hrdatai, hreadyd, 32'h500 ^ PAT); end
        checks++; if (hmaster !== 1'b1 || haddr !== 32'h4010) begin fails++; $display("FAIL starve_cleared: got %b/%h want 1/00004010", hmaster, haddr); end
        step(); idle_all(); #3;
        checks++; if (hmaster !== 1'b0 || haddr !== 32'h504 || hreadyi !== 1'b0) begin fails++; $display("FAIL starve_ireplay: got %b/%h/%b want 0/00000504/0", hmaster, haddr, hreadyi); end
        checks++; if (hreadyd !== 1'b1 || hrdatad !== (32'h4010 ^ PAT)) begin fails++; $display("FAIL starve_ddone: got %b/%h want 1/%h", hreadyd, hrdatad, 32'h4010 ^ PAT); end
        step(); #3;
        checks++; if (hreadyi !== 1'b1 || hrdatai !== (32'h504 ^ PAT)) begin fails++; $display("FAIL starve_ilast: got %b/%h want 1/%h", hreadyi, hrdatai, 32'h504 ^ PAT); end
    endtask

    task automatic test_reset_mid();
        step(); idle_all();
        step();
        htransd = 1'b1; haddrd = 32'h6000; hsized = 3'd2;
        htransi = 1'b1; haddri = 32'h700; hsizei = 3'd2;
        #3;
        checks++; if (hmaster !== 1'b1 || haddr !== 32'h6000) begin fails++; $display("FAIL rmid_dgrant: got %b/%h want 1/00006000", hmaster, haddr); end
        step(); idle_all(); hwdatad = 32'h1234_5678; hresp = 1'b1;
        rst_n = 1'b0; #1;
        checks++; if (htrans !== 2'b00 || haddr !== 32'h0 || hmaster !== 1'b0) begin fails++; $display("FAIL rmid_bus: got %b/%h/%b want 00/0/0", htrans, haddr, hmaster); end
        checks++; if ({hreadyi, hreadyd, hrespi, hrespd} !== 4'b1100) begin fails++; $display("FAIL rmid_master: got %b want 1100", {hreadyi, hreadyd, hrespi, hrespd}); end
        checks++; if (hwdata !== 32'h0) begin fails++; $display("FAIL rmid_hwdata: got %h want 0", hwdata); end
        @(negedge clk); rst_n = 1'b1; hresp = 1'b0;
        step(); idle_all(); htransi = 1'b1; haddri = 32'h800; hsizei = 3'd2; #3;
        checks++; if (htrans !== 2'b10 || hmaster !== 1'b0 || haddr !== 32'h800 || hreadyi !== 1'b1) begin fails++; $display("FAIL rmid_ipass: got %b/%b/%h/%b want 10/0/00000800/1", htrans, hmaster, haddr, hreadyi); end
        step(); idle_all(); #3;
        checks++; if (hreadyi !== 1'b1 || hrdatai !== (32'h800 ^ PAT)) begin fails++; $display("FAIL rmid_irdata: got %b/%h want 1/%h", hreadyi, hrdatai, 32'h800 ^ PAT); end
    endtask

    initial begin
        test_reset();
        test_i_stream();
        test_contend_read();
        test_contend_write();
        test_hready_stall();
        test_starvation();
        test_reset_mid();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "timeout");
    end

endmodule
